// File: rtl/galena_wwl_writer_pkg.sv
// Shared sizes, writer state encoding and phase-counter sizing for the galena
// WWL/WBL programming path.
package galena_pkg;

    localparam int NUM_SPIN  = 256;
    localparam int BIT_DATA  = 4;
    localparam int WWL_WIDTH = NUM_SPIN + 1;
    localparam int WBL_WIDTH = NUM_SPIN * BIT_DATA;
    localparam int ROW_CNT_W = $clog2(WWL_WIDTH);

    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;

    // The phase timer is loaded with cycles-1, so it only needs to hold max-1.
    function automatic int phase_cnt_w(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    localparam int PHASE_CNT_W = phase_cnt_w(DEF_SETUP_CYCLES, DEF_PULSE_CYCLES, DEF_HOLD_CYCLES);

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_WAIT_ROW,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } galena_wr_state_e;

endpackage

// File: rtl/galena_phase_timer.sv
// Loadable down-counter timing the SETUP, PULSE and HOLD phases of a row write.
module galena_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/galena_wwl_writer.sv
// Streams one frame of J/h rows onto the write bit-lines and strobes each
// row into the analog array with a timed one-hot write word-line pulse.
module galena_wwl_writer
    import galena_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 row_valid_i,
    output logic                 row_ready_o,
    input  logic [WBL_WIDTH-1:0] row_data_i,
    output logic [WWL_WIDTH-1:0] wwl_o,
    output logic [WBL_WIDTH-1:0] wbl_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ROW_CNT_W-1:0] row_cnt_o
);

    localparam int PW = phase_cnt_w(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam logic [PW-1:0]        SETUP_LD = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0]        PULSE_LD = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0]        HOLD_LD  = PW'(HOLD_CYCLES - 1);
    localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(NUM_SPIN);

    galena_wr_state_e state;
    logic             tmr_load;
    logic [PW-1:0]    tmr_val;
    logic             tmr_expired;

    galena_phase_timer #(.W(PW)) u_timer (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Each phase arms the timer for the phase that follows it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            WR_WAIT_ROW: if (row_valid_i) begin tmr_load = 1'b1; tmr_val = SETUP_LD; end
            WR_SETUP:    if (tmr_expired) begin tmr_load = 1'b1; tmr_val = PULSE_LD; end
            WR_PULSE:    if (tmr_expired) begin tmr_load = 1'b1; tmr_val = HOLD_LD;  end
            default: ;
        endcase
    end

    // row_cnt_o doubles as the row index: rows completed == row being written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= WR_IDLE;
            wwl_o       <= '0;
            wbl_o       <= '0;
            row_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            row_cnt_o   <= '0;
        end else begin
            done_o <= 1'b0;
            if (state != WR_IDLE && abort_i) begin
                state       <= WR_IDLE;
                wwl_o       <= '0;
                wbl_o       <= '0;
                row_ready_o <= 1'b0;
                busy_o      <= 1'b0;
            end else begin
                case (state)
                    WR_IDLE: begin
                        if (start_i) begin
                            state       <= WR_WAIT_ROW;
                            row_ready_o <= 1'b1;
                            busy_o      <= 1'b1;
                            row_cnt_o   <= '0;
                        end
                    end
                    WR_WAIT_ROW: begin
                        if (row_valid_i) begin
                            wbl_o       <= row_data_i;
                            row_ready_o <= 1'b0;
                            state       <= WR_SETUP;
                        end
                    end
                    WR_SETUP: begin
                        if (tmr_expired) begin
                            wwl_o <= WWL_WIDTH'(1) << row_cnt_o;
                            state <= WR_PULSE;
                        end
                    end
                    WR_PULSE: begin
                        if (tmr_expired) begin
                            wwl_o <= '0;
                            state <= WR_HOLD;
                        end
                    end
                    WR_HOLD: begin
                        if (tmr_expired) begin
                            row_cnt_o <= row_cnt_o + 1'b1;
                            if (row_cnt_o == LAST_ROW) begin
                                state  <= WR_IDLE;
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                                wbl_o  <= '0;
                            end else begin
                                state       <= WR_WAIT_ROW;
                                row_ready_o <= 1'b1;
                            end
                        end
                    end
                    default: state <= WR_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/galena_wwl_writer.md
# galena_wwl_writer

Digital-side programmer for the galena analog Ising macro: accepts one frame of coupling data, `NUM_SPIN` J rows followed by one h row, over a valid/ready stream. Each row is driven onto the macro's write bit lines (WBL), then strobed into the array with a timed one-hot write word-line (WWL) pulse. It is the writing end of the WWL/WBL interface that the galena behavior model receives. It sits between the weight-load DMA/config path and the analog macro.

## Interface
- `NUM_SPIN`, 256: spins per array; the frame has `NUM_SPIN+1` rows.
- `BIT_DATA`, 4: bits per J/h entry.
- `SETUP_CYCLES`, 1: cycles WBL is stable before the WWL pulse; must be ≥1.
- `PULSE_CYCLES`, 2: WWL high time; must be ≥1.
- `HOLD_CYCLES`, 1: cycles WBL is held after WWL falls; must be ≥1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low, single clock domain.
- `start_i`  in  1  begin a frame; sampled only in IDLE.
- `abort_i`  in  1  terminate the frame; acts in any non-IDLE state.
- `row_valid_i`  in  1  row data valid.
- `row_ready_o`  out  1  writer can accept a row.
- `row_data_i`  in  `NUM_SPIN*BIT_DATA`  row payload; MSB is spin 0.
- `wwl_o`  out  `NUM_SPIN+1`  one-hot write word-line; bit `NUM_SPIN` is h.
- `wbl_o`  out  `NUM_SPIN*BIT_DATA`  write bit-lines.
- `busy_o`  out  1  frame in progress.
- `done_o`  out  1  one-cycle pulse after the last row has been written.
- `row_cnt_o`  out  `$clog2(NUM_SPIN+1)`  rows completed in the current frame.

## Operation
- All outputs are registered. In reset: `wwl_o=0`, `wbl_o=0`, `row_ready_o=0`, `busy_o=0`, `done_o=0`, `row_cnt_o=0`. The FSM resets to IDLE.
- FSM states: IDLE, WAIT_ROW, SETUP, PULSE, HOLD.
- IDLE:
  - `start_i=1` moves the FSM to WAIT_ROW and clears `row_cnt_o` and the row index.
  - `busy_o` is 1 in every state except IDLE.
- WAIT_ROW: `row_ready_o=1`. On `row_valid_i & row_ready_o`, `row_data_i` is captured into `wbl_o` and the FSM moves to SETUP. `row_ready_o` is 0 in every other state.
- SETUP: lasts `SETUP_CYCLES`; `wwl_o=0`.
- PULSE: lasts `PULSE_CYCLES`; `wwl_o` has exactly one bit set, at the current row index.
- HOLD: lasts `HOLD_CYCLES`; `wwl_o=0` and `wbl_o` unchanged. On exit, `row_cnt_o` and the row index increment.
  - If the row index was `NUM_SPIN`, the FSM goes to IDLE with `done_o=1` for one cycle.
  - Otherwise it returns to WAIT_ROW.
- In IDLE, `wbl_o` returns to 0 in the cycle `done_o` is asserted or on abort. It is otherwise held between rows.
- `abort_i` in any non-IDLE state: on the next edge the FSM goes to IDLE with `wwl_o=0` and `wbl_o=0`. `done_o` stays 0. `row_cnt_o` keeps the count of completed rows.
- A row accepted in the same cycle as `abort_i` is dropped.
- `start_i` while busy is ignored. `start_i` together with `abort_i` in IDLE starts a frame, because abort has no effect in IDLE.
- Asynchronous reset mid-pulse clears `wwl_o` immediately, with no clock edge required.
- `wwl_o` is never multi-hot, including glitch-free across state changes, because it is registered.

## Timing
- Start: `start_i` sampled at the end of cycle 0 gives `busy_o=1` and `row_ready_o=1` in cycle 1.
- Row period with `row_valid_i` held high is `1+SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES` cycles, which is 5 with defaults.
- With defaults, a row accepted at the end of cycle N gives:
  - SETUP in cycle N+1, with `wbl_o` valid;
  - PULSE in cycles N+2..N+3;
  - HOLD in cycle N+4;
  - `row_ready_o` in cycle N+5.
- Full frame with defaults: the last row (index 256) has its HOLD in cycle 1285. `done_o=1`, `busy_o=0` and `row_cnt_o=257` all appear in cycle 1286.
- Back-pressure: the producer may hold `row_valid_i` low indefinitely in WAIT_ROW; all outputs hold their values meanwhile.

## Structure
- Extend `galena_pkg`:
  - `WWL_WIDTH` and `WBL_WIDTH` are reused from the package;
  - add the state enum `galena_wr_state_e`;
  - add `ROW_CNT_W = $clog2(WWL_WIDTH)`;
  - add `PHASE_CNT_W`, sized for the maximum of the three cycle parameters.
- One sub-module, `galena_phase_timer`: a loadable down-counter that reports expiry and is shared by the SETUP, PULSE and HOLD states.
- The one-hot decode of the row index into `wwl_o` is inlined.

## Test plan
- Reset mid-PULSE (assert `rst_ni=0` during PULSE) → `wwl_o=0` without waiting for a clock edge. After release: IDLE, `row_ready_o=0`, `row_cnt_o=0`.
- Full frame, defaults, `row_valid_i` always 1, row k data = k replicated:
  - exactly 257 PULSE windows, each 2 cycles;
  - `wwl_o` one-hot at bit k, with `wbl_o` = row k data throughout SETUP..HOLD;
  - `done_o` in cycle 1286 and `row_cnt_o=257`.
- Back-pressure: `row_valid_i` random with a 30% duty → the same WWL/WBL sequence as the full-frame test. No row is lost or duplicated, and `row_ready_o` is high only in WAIT_ROW.
- Abort: `abort_i` during the PULSE of row 5 → next cycle `wwl_o=0`, `wbl_o=0`, IDLE, `row_cnt_o=5`, no `done_o`. A new `start_i` then restarts from row 0.
- Ignored start: pulse `start_i` at row 100 → no restart, and `row_cnt_o` keeps incrementing to 257.
- Parameter sweep: `SETUP_CYCLES=3`, `PULSE_CYCLES=1`, `HOLD_CYCLES=2` → row period 7. A bench-side model of the analog array, written through WWL/WBL, must equal the driven frame bit-exactly.
